// File: rtl/count_step_monitor_pkg.sv
// count_mon_pkg
// Shared definitions for the up/down counter step monitor: FSM state
// encodings, step-class codes and default widths.
// No ports (package).
package count_mon_pkg;

    // Default widths of the monitored count and the two statistics counters.
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_WRAP_W = 8;
    localparam int DEF_RUN_W  = 8;

    // FSM state encodings. Values 5..7 cannot be reached and decode as S_ERR.
    localparam logic [2:0] S_EMPTY = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_UP    = 3'd2;
    localparam logic [2:0] S_DOWN  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    // Classification of one sample-to-sample step.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_BAD  = 2'd3
    } step_t;

endpackage

// File: rtl/count_step_monitor_if.sv
// count_step_monitor_if
// Groups the sample stream and the monitor's result signals.
//   en, clear, q_in            : sample stream (driven by master)
//   dir_up, dir_down           : direction of the last classified step
//   wrap_pulse, wrap_count     : wrap event pulse and saturating total
//   run_len                    : length of the current same-direction run
//   step_err, state            : sticky illegal-step flag, FSM state
// master = sample source / observer, slave = the monitor.
interface count_step_monitor_if #(
    parameter int WIDTH  = 8,
    parameter int WRAP_W = 8,
    parameter int RUN_W  = 8
) ();
    logic              en;
    logic              clear;
    logic [WIDTH-1:0]  q_in;
    logic              dir_up;
    logic              dir_down;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic [RUN_W-1:0]  run_len;
    logic              step_err;
    logic [2:0]        state;

    modport master (
        output en, clear, q_in,
        input  dir_up, dir_down, wrap_pulse, wrap_count, run_len, step_err, state
    );

    modport slave (
        input  en, clear, q_in,
        output dir_up, dir_down, wrap_pulse, wrap_count, run_len, step_err, state
    );
endinterface

// File: rtl/count_step_monitor_step_classifier.sv
// step_classifier
// Purely combinational: classifies the step from prev to q_in as up (+1),
// down (-1), hold (0) or bad (anything else), modulo 2^WIDTH, and flags a
// wrap (max->0 on an up step, 0->max on a down step).
//   prev       : previously accepted sample
//   q_in       : current sample
//   step_class : STEP_UP / STEP_DOWN / STEP_HOLD / STEP_BAD
//   wrap       : the step crossed the max/0 boundary
module step_classifier
    import count_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] q_in,
    output step_t            step_class,
    output logic             wrap
);
    logic [WIDTH-1:0] delta;

    // Modulo subtraction: a wrap is just another +1/-1 step.
    assign delta = q_in - prev;

    always_comb begin
        step_class = STEP_BAD;
        wrap       = 1'b0;
        if (delta == WIDTH'(1)) begin
            step_class = STEP_UP;
            wrap       = &prev;
        end else if (&delta) begin
            step_class = STEP_DOWN;
            wrap       = (prev == '0);
        end else if (delta == '0) begin
            step_class = STEP_HOLD;
        end
    end
endmodule

// File: rtl/count_step_monitor.sv
// count_step_monitor
// Checks the output of an up/down counter sample by sample. Each enabled
// sample is classified against the previous one; the monitor tracks the
// direction, the length of the current same-direction run, the number of
// wraps, and latches a sticky error on any illegal step.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : count_step_monitor_if.slave (samples in, results out)
// All results are registered; they reflect the sample of the previous edge.
module count_step_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W,
    parameter int RUN_W  = DEF_RUN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    count_step_monitor_if.slave  bus
);
    logic [2:0]        state_reg,      state_next;
    logic [WIDTH-1:0]  prev_reg,       prev_next;
    logic              dir_up_reg,     dir_up_next;
    logic              dir_down_reg,   dir_down_next;
    logic              wrap_pulse_reg, wrap_pulse_next;
    logic [WRAP_W-1:0] wrap_count_reg, wrap_count_next;
    logic [RUN_W-1:0]  run_len_reg,    run_len_next;
    logic              step_err_reg,   step_err_next;

    step_t step_class;
    logic  step_wrap;

    step_classifier #(.WIDTH(WIDTH)) u_classifier (
        .prev       (prev_reg),
        .q_in       (bus.q_in),
        .step_class (step_class),
        .wrap       (step_wrap)
    );

    // Saturating increments: counters stick at all-ones instead of rolling.
    logic [RUN_W-1:0]  run_len_inc;
    logic [WRAP_W-1:0] wrap_count_inc;
    assign run_len_inc    = (&run_len_reg)    ? run_len_reg    : run_len_reg + RUN_W'(1);
    assign wrap_count_inc = (&wrap_count_reg) ? wrap_count_reg : wrap_count_reg + WRAP_W'(1);

    always_comb begin
        state_next      = state_reg;
        prev_next       = prev_reg;
        dir_up_next     = dir_up_reg;
        dir_down_next   = dir_down_reg;
        wrap_pulse_next = 1'b0;          // pulse lasts only one cycle
        wrap_count_next = wrap_count_reg;
        run_len_next    = run_len_reg;
        step_err_next   = step_err_reg;

        if (bus.en) begin
            case (state_reg)
                S_EMPTY: begin
                    // First sample only primes the history.
                    prev_next     = bus.q_in;
                    state_next    = S_HOLD;
                    run_len_next  = '0;
                    dir_up_next   = 1'b0;
                    dir_down_next = 1'b0;
                end
                S_HOLD, S_UP, S_DOWN: begin
                    prev_next = bus.q_in;
                    case (step_class)
                        STEP_UP: begin
                            state_next    = S_UP;
                            dir_up_next   = 1'b1;
                            dir_down_next = 1'b0;
                            // The current state doubles as the previous direction.
                            run_len_next  = (state_reg == S_UP) ? run_len_inc : RUN_W'(1);
                            if (step_wrap) begin
                                wrap_pulse_next = 1'b1;
                                wrap_count_next = wrap_count_inc;
                            end
                        end
                        STEP_DOWN: begin
                            state_next    = S_DOWN;
                            dir_up_next   = 1'b0;
                            dir_down_next = 1'b1;
                            run_len_next  = (state_reg == S_DOWN) ? run_len_inc : RUN_W'(1);
                            if (step_wrap) begin
                                wrap_pulse_next = 1'b1;
                                wrap_count_next = wrap_count_inc;
                            end
                        end
                        STEP_HOLD: begin
                            state_next    = S_HOLD;
                            dir_up_next   = 1'b0;
                            dir_down_next = 1'b0;
                            run_len_next  = '0;
                        end
                        default: begin
                            // Illegal jump: freeze run_len and wrap_count.
                            state_next    = S_ERR;
                            step_err_next = 1'b1;
                            dir_up_next   = 1'b0;
                            dir_down_next = 1'b0;
                        end
                    endcase
                end
                default: begin
                    // S_ERR is absorbing; stray encodings collapse into it.
                    state_next = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            state_reg      <= S_EMPTY;
            prev_reg       <= '0;
            dir_up_reg     <= 1'b0;
            dir_down_reg   <= 1'b0;
            wrap_pulse_reg <= 1'b0;
            wrap_count_reg <= '0;
            run_len_reg    <= '0;
            step_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            dir_up_reg     <= dir_up_next;
            dir_down_reg   <= dir_down_next;
            wrap_pulse_reg <= wrap_pulse_next;
            wrap_count_reg <= wrap_count_next;
            run_len_reg    <= run_len_next;
            step_err_reg   <= step_err_next;
        end
    end

    assign bus.state      = state_reg;
    assign bus.dir_up     = dir_up_reg;
    assign bus.dir_down   = dir_down_reg;
    assign bus.wrap_pulse = wrap_pulse_reg;
    assign bus.wrap_count = wrap_count_reg;
    assign bus.run_len    = run_len_reg;
    assign bus.step_err   = step_err_reg;
endmodule

// File: tb/tb_count_step_monitor.sv
// Testbench for count_step_monitor: directed scenarios plus a randomized
// run, all checked against a behavioural model of the step rules.
module tb_count_step_monitor;
    import count_mon_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_step_monitor_if #(.WIDTH(8), .WRAP_W(8), .RUN_W(8)) bus ();

    count_step_monitor #(.WIDTH(8), .WRAP_W(8), .RUN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: direction as +1/-1/0, plain integer counters.
    bit m_primed = 0;
    bit m_err    = 0;
    bit m_pulse  = 0;
    int m_prev   = 0;
    int m_dir    = 0;
    int m_run    = 0;
    int m_wraps  = 0;

    logic [22:0] dut_vec;
    assign dut_vec = {bus.state, bus.dir_up, bus.dir_down, bus.wrap_pulse,
                      bus.wrap_count, bus.run_len, bus.step_err};

    function automatic logic [22:0] model_vec();
        logic [2:0] st;
        if (!m_primed)       st = 3'd0;
        else if (m_err)      st = 3'd4;
        else if (m_dir == 0) st = 3'd1;
        else if (m_dir == 1) st = 3'd2;
        else                 st = 3'd3;
        return {st, logic'(m_dir == 1), logic'(m_dir == -1), logic'(m_pulse),
                8'(m_wraps), 8'(m_run), logic'(m_err)};
    endfunction

    task automatic model_step(input bit r, input bit e, input bit c, input int q);
        int d;
        int nd;
        if (!r || c) begin
            m_primed = 0; m_err = 0; m_pulse = 0;
            m_prev = 0; m_dir = 0; m_run = 0; m_wraps = 0;
        end else if (!e) begin
            m_pulse = 0;
        end else if (!m_primed) begin
            m_primed = 1; m_prev = q; m_dir = 0; m_run = 0; m_pulse = 0;
        end else if (m_err) begin
            m_pulse = 0;
        end else begin
            d = (q - m_prev + 256) % 256;
            m_prev = q;
            m_pulse = 0;
            if (d == 0) begin
                m_dir = 0; m_run = 0;
            end else if (d == 1 || d == 255) begin
                nd = (d == 1) ? 1 : -1;
                m_run = (nd == m_dir) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                m_dir = nd;
                if ((nd == 1 && q == 0) || (nd == -1 && q == 255)) begin
                    m_pulse = 1;
                    if (m_wraps < 255) m_wraps++;
                end
            end else begin
                m_err = 1; m_dir = 0;
            end
        end
    endtask

    // Drive one cycle, advance the model at the edge, settle 1 time unit.
    task automatic cycle(input bit r, input bit e, input bit c, input int q);
        rst_n      = r;
        bus.en     = e;
        bus.clear  = c;
        bus.q_in   = q[7:0];
        @(posedge clk);
        model_step(r, e, c, q);
        #1;
        $display("[TB] rst_n=%0b en=%0b clr=%0b q=%0d -> st=%0d up=%0b dn=%0b wp=%0b wc=%0d run=%0d err=%0b",
                 r, e, c, q, bus.state, bus.dir_up, bus.dir_down, bus.wrap_pulse,
                 bus.wrap_count, bus.run_len, bus.step_err);
    endtask

    task automatic test_reset();
        cycle(0, 1, 0, int'($urandom_range(0, 255)));
        n_tests++;
        if (dut_vec !== 23'd0) begin
            n_fail++;
            $display("FAIL reset: got %h required 0", dut_vec);
        end
    endtask

    task automatic test_count_up();
        int seq [4] = '{5, 6, 7, 8};
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, seq[i]);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL count_up q=%0d: got %h required %h", seq[i], dut_vec, model_vec());
            end
            if (i > 0) begin
                n_tests++;
                if (bus.state !== S_UP || bus.dir_up !== 1'b1 || bus.run_len !== 8'(i)
                    || bus.wrap_count !== 8'd0 || bus.step_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL count_up_run q=%0d: got st=%0d up=%0b run=%0d required st=2 up=1 run=%0d",
                             seq[i], bus.state, bus.dir_up, bus.run_len, i);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        int seq [4] = '{254, 255, 0, 1};
        logic exp_wp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, seq[i]);
            n_tests++;
            if (dut_vec !== model_vec() || bus.wrap_pulse !== exp_wp[i]) begin
                n_fail++;
                $display("FAIL up_wrap q=%0d: got %h wp=%0b required %h wp=%0b",
                         seq[i], dut_vec, bus.wrap_pulse, model_vec(), exp_wp[i]);
            end
        end
        n_tests++;
        if (bus.wrap_count !== 8'd1 || bus.run_len !== 8'd3) begin
            n_fail++;
            $display("FAIL up_wrap_end: got wc=%0d run=%0d required wc=1 run=3", bus.wrap_count, bus.run_len);
        end
    endtask

    task automatic test_down_wrap();
        int seq [4] = '{1, 0, 255, 0};
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, seq[i]);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL down_wrap q=%0d: got %h required %h", seq[i], dut_vec, model_vec());
            end
            if (i == 2) begin
                n_tests++;
                if (bus.dir_down !== 1'b1 || bus.wrap_count !== 8'd1 || bus.run_len !== 8'd2) begin
                    n_fail++;
                    $display("FAIL down_wrap_dn: got dn=%0b wc=%0d run=%0d required dn=1 wc=1 run=2",
                             bus.dir_down, bus.wrap_count, bus.run_len);
                end
            end
        end
        n_tests++;
        if (bus.dir_up !== 1'b1 || bus.run_len !== 8'd1 || bus.wrap_count !== 8'd2) begin
            n_fail++;
            $display("FAIL down_wrap_rev: got up=%0b run=%0d wc=%0d required up=1 run=1 wc=2",
                     bus.dir_up, bus.run_len, bus.wrap_count);
        end
    endtask

    task automatic test_hold_idle();
        // Idle right after a wrap must drop the pulse.
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 255);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 77);
        n_tests++;
        if (bus.wrap_pulse !== 1'b0 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL idle_pulse: got %h wp=%0b required %h wp=0", dut_vec, bus.wrap_pulse, model_vec());
        end
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 10);
        cycle(1, 1, 0, 10);
        n_tests++;
        if (bus.state !== S_HOLD || bus.run_len !== 8'd0 || bus.dir_up !== 1'b0 || bus.dir_down !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got st=%0d run=%0d required st=1 run=0", bus.state, bus.run_len);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, int'($urandom_range(0, 255)));
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL idle cyc=%0d: got %h required %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_illegal();
        int seq [7] = '{20, 23, 24, 25, 26, 27, 28};
        bit clr [7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [2:0] exp_st [7] = '{3'd1, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1, 3'd2};
        logic exp_err [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cycle(1, 1, clr[i], seq[i]);
            n_tests++;
            if (dut_vec !== model_vec() || bus.state !== exp_st[i] || bus.step_err !== exp_err[i]) begin
                n_fail++;
                $display("FAIL illegal q=%0d clr=%0b: got %h st=%0d err=%0b required %h st=%0d err=%0b",
                         seq[i], clr[i], dut_vec, bus.state, bus.step_err, model_vec(), exp_st[i], exp_err[i]);
            end
        end
    endtask

    task automatic test_saturation();
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            cycle(1, 1, 0, i % 256);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL saturation step=%0d: got %h required %h", i, dut_vec, model_vec());
            end
        end
        n_tests++;
        if (bus.run_len !== 8'd255 || bus.wrap_count !== 8'd1) begin
            n_fail++;
            $display("FAIL saturation_end: got run=%0d wc=%0d required run=255 wc=1", bus.run_len, bus.wrap_count);
        end
        cycle(0, 1, 0, 301 % 256);
        n_tests++;
        if (dut_vec !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h required 0", dut_vec);
        end
    endtask

    task automatic test_random();
        int q;
        bit r, e, c;
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) != 0);
            c = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) q = int'($urandom_range(0, 255));
            else q = (m_prev + int'($urandom_range(0, 2)) + 255) % 256;
            cycle(r, e, c, q);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d q=%0d: got %h required %h", i, q, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        bus.en    = 1'b0;
        bus.clear = 1'b0;
        bus.q_in  = '0;
        test_reset();
        test_count_up();
        test_up_wrap();
        test_down_wrap();
        test_hold_idle();
        test_illegal();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
